branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/rv32i_types.sv | 31 +++
 rtl/bp_bht.sv | 47 ++++
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Holds the branch-history counter encoding, the default BHT index width and
// the saturating-counter next-state helper used by the branch predictor.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam int BP_IDX_BITS_DEFAULT = 6;

    // Two-bit saturating counter step: taken moves toward ST, not-taken toward SNT.
    function automatic bht_state_t bht_next(input bht_state_t cur, input logic taken);
        bht_state_t nxt;
        nxt = cur;
        case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_bht.sv
// Branch history table storage: 2**IDX_BITS two-bit counters.
// Ports:
//   clk, rst            clock and synchronous active-high reset (all entries -> WNT)
//   rd_idx / rd_state   combinational read port
//   wr_en, wr_idx,      synchronous write port; a same-cycle read of the written
//   wr_state            entry returns the old value
// Kept in flops rather than block RAM: the whole table must clear in one
// cycle and the read has to be zero-latency.
module bp_bht
    import rv32i_types::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output bht_state_t          rd_state,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  bht_state_t          wr_state
);

    localparam int DEPTH = 1 << IDX_BITS;

    bht_state_t        table_reg [DEPTH];
    logic [DEPTH-1:0]  wr_hit;

    // One-hot write decode.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign wr_hit[gi] = wr_en && (wr_idx == IDX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                table_reg[i] <= WNT;
            end else if (wr_hit[i]) begin
                table_reg[i] <= wr_state;
            end
        end
    end

    assign rd_state = table_reg[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal (2-bit counter) branch predictor with EX-stage mispredict detection.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_pc -> pred_taken         fetch-stage lookup, combinational
//   ex_valid, ex_is_branch,     resolved branch from EX; updates the table
//   ex_pc, ex_br_en,            at the clock edge
//   ex_pred_taken, ex_target
//   flush, redirect_pc          mispredict squash and the correct next PC
//   stat_branches,              performance counters, only when the macro
//   stat_mispredicts            BP_STATS_EN is defined
// The table is untagged: PCs sharing bits [IDX_BITS+1:2] share one counter.
module branch_predictor
    import rv32i_types::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  rv32i_word  if_pc,
    output logic       pred_taken,
    input  logic       ex_valid,
    input  logic       ex_is_branch,
    input  rv32i_word  ex_pc,
    input  logic       ex_br_en,
    input  logic       ex_pred_taken,
    input  rv32i_word  ex_target,
    output logic       flush,
    output rv32i_word  redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    bht_state_t          rd_state;
    bht_state_t          ex_state;
    bht_state_t          wr_state;
    logic                upd;

    assign rd_idx = if_pc[IDX_BITS+1:2];
    assign wr_idx = ex_pc[IDX_BITS+1:2];
    assign upd    = ex_valid && ex_is_branch;

    // Upper and byte-offset PC bits do not take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

    // Second read of the table for the EX-side read-modify-write.
    bp_bht #(.IDX_BITS(IDX_BITS)) u_bht_ex (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (wr_idx),
        .rd_state (ex_state),
        .wr_en    (upd),
        .wr_idx   (wr_idx),
        .wr_state (wr_state)
    );

    // Fetch-side copy; written identically so both copies always agree.
    bp_bht #(.IDX_BITS(IDX_BITS)) u_bht_if (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_state (rd_state),
        .wr_en    (upd),
        .wr_idx   (wr_idx),
        .wr_state (wr_state)
    );

    assign wr_state = bht_next(ex_state, ex_br_en);

    assign pred_taken  = !rst && rd_state[1];
    assign flush       = !rst && upd && (ex_br_en != ex_pred_taken);
    assign redirect_pc = !flush   ? 32'd0 :
                         ex_br_en ? ex_target : (ex_pc + 32'd4);

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_reg    <= 32'd0;
            stat_mispredicts_reg <= 32'd0;
        end else begin
            if (upd) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (flush) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor (IDX_BITS = 6).
module tb_branch_predictor;
    import rv32i_types::*;

    logic       clk;
    logic       rst;
    rv32i_word  if_pc;
    logic       pred_taken;
    logic       ex_valid;
    logic       ex_is_branch;
    rv32i_word  ex_pc;
    logic       ex_br_en;
    logic       ex_pred_taken;
    rv32i_word  ex_target;
    logic       flush;
    rv32i_word  redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    branch_predictor #(.IDX_BITS(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_br_en      (ex_br_en),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input rv32i_word pc, input logic taken, input logic pred, input rv32i_word tgt);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_br_en      = taken;
        ex_pred_taken = pred;
        ex_target     = tgt;
        #1;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_br_en      = 1'b0;
        ex_pred_taken = 1'b0;
        #1;
    endtask

    initial begin
        // Reset with a valid mispredicting branch in EX at the same index.
        rst = 1'b1;
        if_pc = 32'h100;
        br(32'h100, 1'b1, 1'b0, 32'h40);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        chk("rst_redir", redirect_pc, 32'd0);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_entry", {31'd0, pred_taken}, 32'd0);
`ifdef BP_STATS_EN
        chk("rst_stat_br", stat_branches, 32'd0);
        chk("rst_stat_mis", stat_mispredicts, 32'd0);
`endif

        // WNT + one taken -> WT.
        br(32'h100, 1'b1, 1'b1, 32'h1000);
        chk("t1_flush", {31'd0, flush}, 32'd0);
        chk("t1_redir", redirect_pc, 32'd0);
        chk("t1_pred_pre", {31'd0, pred_taken}, 32'd0);
        tick();
        idle();
        chk("t1_pred_post", {31'd0, pred_taken}, 32'd1);

        // Saturate at ST, then walk back down (0x200 aliases 0x100).
        if_pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            br(32'h200, 1'b1, 1'b1, 32'h2000);
            tick();
        end
        idle();
        chk("sat_st_pred", {31'd0, pred_taken}, 32'd1);
        br(32'h200, 1'b0, 1'b1, 32'h2000);
        chk("nt1_flush", {31'd0, flush}, 32'd1);
        chk("nt1_redir", redirect_pc, 32'h204);
        tick();
        idle();
        chk("st_to_wt", {31'd0, pred_taken}, 32'd1);
        br(32'h200, 1'b0, 1'b0, 32'h2000);
        chk("nt2_flush", {31'd0, flush}, 32'd0);
        tick();
        idle();
        chk("wt_to_wnt", {31'd0, pred_taken}, 32'd0);

        // Mispredict redirect in both directions.
        br(32'h300, 1'b1, 1'b0, 32'h40);
        chk("mp_tk_flush", {31'd0, flush}, 32'd1);
        chk("mp_tk_redir", redirect_pc, 32'h40);
        tick();
        br(32'h300, 1'b0, 1'b1, 32'h40);
        chk("mp_nt_flush", {31'd0, flush}, 32'd1);
        chk("mp_nt_redir", redirect_pc, 32'h304);
        tick();

        // PC+4 wraps to zero.
        if_pc = 32'hFFFF_FFFC;
        br(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h8);
        chk("wrap_flush", {31'd0, flush}, 32'd1);
        chk("wrap_redir", redirect_pc, 32'h0);
        tick();
        idle();
        chk("wrap_snt", {31'd0, pred_taken}, 32'd0);

        // Saturation at SNT: not-taken holds, two taken reach WT.
        br(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h8);
        tick();
        idle();
        chk("snt_hold", {31'd0, pred_taken}, 32'd0);
        br(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8);
        tick();
        idle();
        chk("snt_to_wnt", {31'd0, pred_taken}, 32'd0);
        br(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h8);
        tick();
        idle();
        chk("wnt_to_wt", {31'd0, pred_taken}, 32'd1);

        // Same-index lookup during update, then an aliasing PC.
        if_pc = 32'h80;
        br(32'h80, 1'b1, 1'b1, 32'h90);
        chk("byp_pre", {31'd0, pred_taken}, 32'd0);
        tick();
        idle();
        chk("byp_post", {31'd0, pred_taken}, 32'd1);
        if_pc = 32'h180;
        #1;
        chk("alias_pred", {31'd0, pred_taken}, 32'd1);

        // Invalid or non-branch EX must not touch the table or flush.
        if_pc = 32'h80;
        br(32'h80, 1'b0, 1'b1, 32'h90);
        ex_valid = 1'b0;
        #1;
        chk("inv_flush", {31'd0, flush}, 32'd0);
        chk("inv_redir", redirect_pc, 32'd0);
        tick();
        br(32'h80, 1'b0, 1'b1, 32'h90);
        ex_is_branch = 1'b0;
        #1;
        chk("nobr_flush", {31'd0, flush}, 32'd0);
        tick();
        idle();
        chk("no_change", {31'd0, pred_taken}, 32'd1);

`ifdef BP_STATS_EN
        chk("run_stat_br", stat_branches, 32'd14);
        chk("run_stat_mis", stat_mispredicts, 32'd5);

        // Fresh reset, then three branches with one mispredict.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_stat_br", stat_branches, 32'd0);
        br(32'h100, 1'b1, 1'b1, 32'h10);
        tick();
        br(32'h104, 1'b0, 1'b0, 32'h10);
        tick();
        br(32'h108, 1'b1, 1'b0, 32'h10);
        tick();
        idle();
        chk("stat_br3", stat_branches, 32'd3);
        chk("stat_mis1", stat_mispredicts, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
